conv_window_mac: RTL and testbench

CONV_WINDOW_MAC -- requirements
Module: conv_window_mac

---
 rtl/conv_window_mac.sv | 123 ++++++++++++
 tb/tb_conv_window_mac.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/conv_window_mac.sv
// conv_window_mac
// Computes the unsigned sum of the 16 byte products of a 4x4 pixel window
// and a 4x4 kernel. One row is processed per clock, so a request takes
// one accept cycle, four accumulate cycles and one DONE cycle.
//
// Ports:
//   clk     rising-edge clock for all state
//   rst     asynchronous active-high reset
//   start   request a new multiply-accumulate (sampled only in IDLE)
//   window  4x4 unsigned bytes; [127:96] is row 0, MS byte of a row is column 0
//   filter  4x4 unsigned kernel bytes, same packing as window
//   busy    high whenever the FSM is not in IDLE
//   done    one-cycle pulse when result holds a new sum
//   result  20-bit sum of the 16 products, held between operations
module conv_window_mac (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] window,
  input  logic [127:0] filter,
  output logic         busy,
  output logic         done,
  output logic [19:0]  result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic [1:0]    row_q;
  logic [19:0]   acc_q;
  logic [127:0]  win_q;
  logic [127:0]  filt_q;
  logic [19:0]   result_q;
  logic          busy_q;
  logic          done_q;

  logic [31:0]   win_row;
  logic [31:0]   filt_row;
  logic [15:0]   prod;
  logic [17:0]   row_sum;
  logic [19:0]   acc_d;

  // Row r occupies bits [127-32r -: 32] of the latched operands.
  // NOTE: every combinational output gets a default first, so no path
  // through the block leaves a variable unassigned and infers a latch.
  always_comb begin
    win_row  = '0;
    filt_row = '0;
    prod     = '0;
    row_sum  = '0;
    case (row_q)
      2'd0: begin win_row = win_q[127:96]; filt_row = filt_q[127:96]; end
      2'd1: begin win_row = win_q[95:64];  filt_row = filt_q[95:64];  end
      2'd2: begin win_row = win_q[63:32];  filt_row = filt_q[63:32];  end
      default: begin win_row = win_q[31:0]; filt_row = filt_q[31:0]; end
    endcase
    for (int c = 0; c < 4; c++) begin
      prod    = 16'(win_row[31-8*c -: 8]) * 16'(filt_row[31-8*c -: 8]);
      row_sum = row_sum + 18'(prod);
    end
    // 16*255*255 fits in 20 bits, so the accumulator can never overflow.
    acc_d = acc_q + 20'(row_sum);
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      row_q    <= '0;
      acc_q    <= '0;
      win_q    <= '0;
      filt_q   <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            // Operands are captured here so later input changes cannot
            // disturb the sum in progress.
            win_q   <= window;
            filt_q  <= filter;
            acc_q   <= '0;
            row_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          acc_q <= acc_d;
          row_q <= row_q + 2'd1;
          if (row_q == 2'd3) begin
            result_q <= acc_d;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          // start is deliberately ignored here; it is not queued.
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_conv_window_mac.sv
// tb_conv_window_mac
// Directed bench for conv_window_mac. Inputs are driven and outputs are
// sampled on the falling clock edge, half a period away from the active edge.
module tb_conv_window_mac;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] window;
  logic [127:0] filter;
  logic         busy;
  logic         done;
  logic [19:0]  result;

  int n_compared;
  int n_mismatched;
  logic [19:0] exp_result;

  conv_window_mac dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .window (window),
    .filter (filter),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_compared++;
    assert (observed === expected)
    else begin
      n_mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // One start pulse, then follow the five busy cycles. Optionally clears the
  // window right after acceptance to show the operands were latched.
  task automatic run_op(input string tag, input logic [127:0] w,
                        input logic [127:0] f, input logic [19:0] exp_sum,
                        input bit zap_window);
    window = w;
    filter = f;
    start  = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 1) begin
        start = 1'b0;
        if (zap_window) window = '0;
      end
      check({tag, " busy"}, 32'(busy), 32'd1);
      check({tag, " done"}, 32'(done), (i == 5) ? 32'd1 : 32'd0);
      if (i < 5) check({tag, " result held"}, 32'(result), 32'(exp_result));
    end
    exp_result = exp_sum;
    check({tag, " result"}, 32'(result), 32'(exp_result));
    @(negedge clk);
    check({tag, " busy end"}, 32'(busy), 32'd0);
    check({tag, " done end"}, 32'(done), 32'd0);
    // Idle with start low: result must hold while inputs wander.
    window = ~w;
    filter = ~f;
    repeat (2) @(negedge clk);
    check({tag, " idle hold"}, 32'(result), 32'(exp_result));
    check({tag, " idle done"}, 32'(done), 32'd0);
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    exp_result   = '0;
    rst    = 1'b1;
    start  = 1'b0;
    window = '0;
    filter = '0;
    repeat (2) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", 32'(result), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle after reset", 32'(busy), 32'd0);

    // All-ones operands: maximum sum 16*255*255.
    run_op("all ones", {16{8'hFF}}, {16{8'hFF}}, 20'd1040400, 1'b0);

    // Identity-like kernel picking bytes (0,0)=0 and (3,3)=15.
    run_op("identity", 128'h000102030405060708090A0B0C0D0E0F,
           128'h01000000000000000000000000000001, 20'd15, 1'b0);

    // Distinct rows: 4*16*(1+2+3+4) = 640.
    run_op("rows", 128'h01010101020202020303030304040404,
           {16{8'h10}}, 20'd640, 1'b0);

    // Window cleared after acceptance; latched value gives 16*255 = 4080.
    run_op("stability", {16{8'hFF}}, {16{8'h01}}, 20'd4080, 1'b1);

    // start held high: accept, 5 busy cycles, one idle cycle, repeat.
    window = {16{8'h02}};
    filter = {16{8'h03}};
    start  = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      check("cont busy", 32'(busy), (i == 6 || i == 12) ? 32'd0 : 32'd1);
      check("cont done", 32'(done), (i == 5 || i == 11) ? 32'd1 : 32'd0);
      if (i == 5 || i == 11) check("cont result", 32'(result), 32'd96);
    end
    start = 1'b0;
    exp_result = 20'd96;
    @(negedge clk);
    check("cont idle", 32'(busy), 32'd0);

    // Reset in the third CALC cycle aborts with no done pulse.
    window = {16{8'hFF}};
    filter = {16{8'hFF}};
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("pre-abort busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #2;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort result", 32'(result), 32'd0);
    rst = 1'b0;
    exp_result = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post-abort done", 32'(done), 32'd0);
      check("post-abort busy", 32'(busy), 32'd0);
    end
    check("post-abort result", 32'(result), 32'd0);

    // First start after reset behaves normally.
    run_op("after reset", {16{8'hFF}}, {16{8'hFF}}, 20'd1040400, 1'b0);

    // Zero kernel with an arbitrary window.
    run_op("zero filter", 128'hDEADBEEF_0123_4567_89AB_CDEF_A5A5_5A5A,
           '0, 20'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_compared, n_mismatched);
    $finish;
  end

endmodule
